// File: rtl/bp_fe_btb_update_queue_if.sv
// ============================================================================
// Module   : bp_fe_btb_update_queue_if
// Purpose  : Update-request side and BTB write-port side of the update queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_fe_btb_update_queue_if #(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 9,
  parameter int btb_idx_width_p = 6
);
  logic                       v_i;
  logic                       ready_and_o;
  logic                       clr_i;
  logic                       jmp_i;
  logic [btb_tag_width_p-1:0] tag_i;
  logic [btb_idx_width_p-1:0] idx_i;
  logic [vaddr_width_p-1:0]   tgt_i;

  logic                       w_v_o;
  logic                       w_clr_o;
  logic                       w_jmp_o;
  logic [btb_tag_width_p-1:0] w_tag_o;
  logic [btb_idx_width_p-1:0] w_idx_o;
  logic [vaddr_width_p-1:0]   w_tgt_o;
  logic                       w_force_o;
  logic                       w_yumi_i;

  // Queue view
  modport slave (
    input  v_i, clr_i, jmp_i, tag_i, idx_i, tgt_i, w_yumi_i,
    output ready_and_o, w_v_o, w_clr_o, w_jmp_o, w_tag_o, w_idx_o, w_tgt_o, w_force_o
  );

  // Requester / BTB view
  modport master (
    output v_i, clr_i, jmp_i, tag_i, idx_i, tgt_i, w_yumi_i,
    input  ready_and_o, w_v_o, w_clr_o, w_jmp_o, w_tag_o, w_idx_o, w_tgt_o, w_force_o
  );
endinterface

`default_nettype wire

// File: rtl/bp_fe_btb_update_queue.sv
// ============================================================================
// Module   : bp_fe_btb_update_queue
// Purpose  : Index-merging FIFO of BTB updates feeding the BTB write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_btb_update_queue #(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 9,
  parameter int btb_idx_width_p = 6,
  parameter int els_p           = 4,
  parameter int stall_limit_p   = 8,
  localparam int c_cnt_w        = $clog2(els_p + 1)
) (
  input  wire logic               clk_i,
  input  wire logic               reset_i,
  input  wire logic               init_done_i,
  input  wire logic               flush_i,
  bp_fe_btb_update_queue_if.slave bus,
  output logic [c_cnt_w-1:0]      count_o
);

  localparam int c_ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int c_age_w = $clog2(stall_limit_p + 1);
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(els_p);
  localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(els_p - 1);
  localparam logic [c_age_w-1:0] c_age_max = c_age_w'(stall_limit_p);

  logic [els_p-1:0]           r_vld;
  logic [els_p-1:0]           r_clr;
  logic [els_p-1:0]           r_jmp;
  logic [btb_tag_width_p-1:0] r_tag [els_p];
  logic [btb_idx_width_p-1:0] r_idx [els_p];
  logic [vaddr_width_p-1:0]   r_tgt [els_p];
  logic [c_ptr_w-1:0]         r_rptr;
  logic [c_ptr_w-1:0]         r_wptr;
  logic [c_cnt_w-1:0]         r_count;
  logic [c_age_w-1:0]         r_age;

  logic             w_full;
  logic             w_wv;
  logic             w_enq;
  logic             w_deq;
  logic             w_append;
  logic [els_p-1:0] w_hit;

  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_count == c_full);
  assign w_wv     = (r_count != '0) & init_done_i;
  assign w_enq    = bus.v_i & bus.ready_and_o;
  assign w_deq    = bus.w_yumi_i & w_wv & ~flush_i;
  assign w_append = w_enq & ~(|w_hit);

  // A head that leaves this cycle is no longer a merge target; the request appends instead.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < els_p; i++) begin
      w_hit[i] = r_vld[i] & (r_idx[i] == bus.idx_i)
               & ~(w_deq & (c_ptr_w'(i) == r_rptr));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if ((w_enq & w_hit[i]) | (w_append & (c_ptr_w'(i) == r_wptr))) begin
        r_clr[i] <= bus.clr_i;
        r_jmp[i] <= bus.jmp_i;
        r_tag[i] <= bus.tag_i;
        r_idx[i] <= bus.idx_i;
        r_tgt[i] <= bus.tgt_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= f_next(r_rptr);
      end
      if (w_append) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= f_next(r_wptr);
      end
      r_count <= r_count + c_cnt_w'(w_append) - c_cnt_w'(w_deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_age <= '0;
    end else if (flush_i | bus.w_yumi_i | ~w_wv) begin
      r_age <= '0;
    end else if (r_age != c_age_max) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign bus.ready_and_o = ~w_full & ~flush_i;
  assign bus.w_v_o       = w_wv;
  assign bus.w_clr_o     = r_clr[r_rptr];
  assign bus.w_jmp_o     = r_jmp[r_rptr];
  assign bus.w_tag_o     = r_tag[r_rptr];
  assign bus.w_idx_o     = r_idx[r_rptr];
  assign bus.w_tgt_o     = r_tgt[r_rptr];
  assign bus.w_force_o   = w_wv & ((r_age == c_age_max) | w_full);
  assign count_o         = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_btb_update_queue.sv
// ============================================================================
// Module   : tb_bp_fe_btb_update_queue
// Purpose  : Directed bench with a merging scoreboard for the BTB update queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_fe_btb_update_queue;

  typedef struct packed {
    logic        clr;
    logic        jmp;
    logic [8:0]  tag;
    logic [5:0]  idx;
    logic [38:0] tgt;
  } entry_t;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       init_done_i;
  logic       flush_i;
  logic       yumi_tie;
  logic       yumi_drv;
  logic [2:0] count_o;

  int     n_cmp = 0;
  int     n_bad = 0;
  entry_t sb[$];

  always #5 clk_i = ~clk_i;

  bp_fe_btb_update_queue_if #(.vaddr_width_p(39), .btb_tag_width_p(9), .btb_idx_width_p(6)) bus ();

  assign bus.w_yumi_i = yumi_tie ? bus.w_v_o : yumi_drv;

  bp_fe_btb_update_queue #(
    .vaddr_width_p(39), .btb_tag_width_p(9), .btb_idx_width_p(6),
    .els_p(4), .stall_limit_p(8)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .init_done_i (init_done_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [5:0] idx, input logic [38:0] tgt);
    bus.v_i   = v;
    bus.idx_i = idx;
    bus.tgt_i = tgt;
    bus.clr_i = idx[0];
    bus.jmp_i = idx[1];
    bus.tag_i = {3'b000, idx} ^ 9'h0a5;
  endtask

  // Reference: pop first, then merge into a pending same-index entry or append.
  always @(negedge clk_i) begin
    entry_t got, req, exp;
    bit     found;
    if (!reset_i || flush_i) begin
      sb.delete();
    end else begin
      if (bus.w_v_o && bus.w_yumi_i) begin
        got = '{bus.w_clr_o, bus.w_jmp_o, bus.w_tag_o, bus.w_idx_o, bus.w_tgt_o};
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("head_entry", 64'(got), 64'(exp));
        end
      end
      if (bus.v_i && bus.ready_and_o) begin
        req   = '{bus.clr_i, bus.jmp_i, bus.tag_i, bus.idx_i, bus.tgt_i};
        found = 1'b0;
        foreach (sb[j]) begin
          if (sb[j].idx == bus.idx_i) begin
            sb[j] = req;
            found = 1'b1;
          end
        end
        if (!found) sb.push_back(req);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i     = 1'b0;
    init_done_i = 1'b1;
    flush_i     = 1'b0;
    yumi_tie    = 1'b0;
    yumi_drv    = 1'b0;
    set_req(1'b0, 6'd0, 39'd0);
    tick();
    tick();
    check("rst_wv",    64'(bus.w_v_o), 64'd0);
    check("rst_force", 64'(bus.w_force_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(bus.ready_and_o), 64'd1);
    reset_i = 1'b1;
    tick();

    // Streaming with yumi tied to w_v_o
    yumi_tie = 1'b1;
    set_req(1'b1, 6'd5, 39'h1005);
    #1 check("t1_wv_before", 64'(bus.w_v_o), 64'd0);
    tick();
    check("t1_wv_after", 64'(bus.w_v_o), 64'd1);
    check("t1_idx5",     64'(bus.w_idx_o), 64'd5);
    set_req(1'b1, 6'd6, 39'h1006);
    tick();
    check("t1_idx6", 64'(bus.w_idx_o), 64'd6);
    set_req(1'b1, 6'd7, 39'h1007);
    tick();
    check("t1_idx7", 64'(bus.w_idx_o), 64'd7);
    set_req(1'b0, 6'd0, 39'd0);
    tick();
    check("t1_count0", 64'(count_o), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    yumi_tie = 1'b0;

    // Merge onto a stalled head
    set_req(1'b1, 6'd3, 39'h100);
    tick();
    set_req(1'b1, 6'd3, 39'h200);
    tick();
    set_req(1'b0, 6'd0, 39'd0);
    check("t2_merge_count", 64'(count_o), 64'd1);
    check("t2_merge_tgt",   64'(bus.w_tgt_o), 64'h200);
    yumi_drv = 1'b1;
    tick();
    yumi_drv = 1'b0;
    check("t2_drain", 64'(count_o), 64'd0);

    // Same index while the head leaves: appended, not merged
    set_req(1'b1, 6'd3, 39'h100);
    tick();
    yumi_drv = 1'b1;
    set_req(1'b1, 6'd3, 39'h200);
    tick();
    yumi_drv = 1'b0;
    set_req(1'b0, 6'd0, 39'd0);
    check("t2b_count", 64'(count_o), 64'd1);
    check("t2b_tgt",   64'(bus.w_tgt_o), 64'h200);
    yumi_drv = 1'b1;
    tick();
    yumi_drv = 1'b0;
    check("t2b_drain", 64'(count_o), 64'd0);

    // Fill to capacity
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 6'(10 + i), 39'(32'h3000 + i));
      tick();
    end
    set_req(1'b0, 6'd0, 39'd0);
    check("t3_full_count", 64'(count_o), 64'd4);
    check("t3_full_ready", 64'(bus.ready_and_o), 64'd0);
    check("t3_full_force", 64'(bus.w_force_o), 64'd1);
    yumi_drv = 1'b1;
    set_req(1'b1, 6'd20, 39'h2000);
    #1 check("t3_no_bypass", 64'(bus.ready_and_o), 64'd0);
    tick();
    yumi_drv = 1'b0;
    set_req(1'b0, 6'd0, 39'd0);
    check("t3_pop_count", 64'(count_o), 64'd3);
    check("t3_pop_ready", 64'(bus.ready_and_o), 64'd1);
    yumi_drv = 1'b1;
    repeat (3) tick();
    yumi_drv = 1'b0;
    check("t3_drain", 64'(count_o), 64'd0);

    // Stall aging
    set_req(1'b1, 6'd30, 39'h3030);
    tick();
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("t4_force_c%0d", k), 64'(bus.w_force_o), 64'(k == 9));
      if (k == 1) set_req(1'b1, 6'd31, 39'h3131);
      else        set_req(1'b0, 6'd0, 39'd0);
      tick();
    end
    check("t4_force_sat", 64'(bus.w_force_o), 64'd1);
    yumi_drv = 1'b1;
    tick();
    yumi_drv = 1'b0;
    check("t4_force_clr", 64'(bus.w_force_o), 64'd0);
    check("t4_next_wv",   64'(bus.w_v_o), 64'd1);
    check("t4_next_idx",  64'(bus.w_idx_o), 64'd31);
    yumi_drv = 1'b1;
    tick();
    yumi_drv = 1'b0;
    check("t4_drain", 64'(count_o), 64'd0);

    // Flush with a concurrent request
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 6'(40 + i), 39'(32'h4000 + i));
      tick();
    end
    flush_i = 1'b1;
    set_req(1'b1, 6'd43, 39'h4300);
    #1 check("t5_flush_ready", 64'(bus.ready_and_o), 64'd0);
    check("t5_flush_wv", 64'(bus.w_v_o), 64'd1);
    tick();
    flush_i = 1'b0;
    set_req(1'b0, 6'd0, 39'd0);
    check("t5_count", 64'(count_o), 64'd0);
    check("t5_wv",    64'(bus.w_v_o), 64'd0);
    tick();
    check("t5_not_stored", 64'(count_o), 64'd0);

    // Accumulate before BTB init completes
    init_done_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 2) set_req(1'b1, 6'(50 + i), 39'(32'h5000 + i));
      else       set_req(1'b0, 6'd0, 39'd0);
      tick();
      check($sformatf("t6_wv_%0d", i),    64'(bus.w_v_o), 64'd0);
      check($sformatf("t6_force_%0d", i), 64'(bus.w_force_o), 64'd0);
    end
    check("t6_count", 64'(count_o), 64'd2);
    init_done_i = 1'b1;
    #1 check("t6_wv_init", 64'(bus.w_v_o), 64'd1);
    check("t6_idx_init", 64'(bus.w_idx_o), 64'd50);
    yumi_drv = 1'b1;
    tick();
    tick();
    yumi_drv = 1'b0;
    check("t6_drain", 64'(count_o), 64'd0);

    // Asynchronous reset between edges
    set_req(1'b1, 6'd60, 39'h6000);
    tick();
    set_req(1'b1, 6'd61, 39'h6001);
    tick();
    set_req(1'b0, 6'd0, 39'd0);
    check("t7_pending", 64'(count_o), 64'd2);
    #2 reset_i = 1'b0;
    #1 check("t7_async_wv", 64'(bus.w_v_o), 64'd0);
    check("t7_async_count", 64'(count_o), 64'd0);
    tick();
    reset_i = 1'b1;
    tick();
    check("t7_post_wv",    64'(bus.w_v_o), 64'd0);
    check("t7_post_count", 64'(count_o), 64'd0);
    check("t7_post_ready", 64'(bus.ready_and_o), 64'd1);
    check("t7_sb_empty",   64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_fe_btb_update_queue.md
Name: bp_fe_btb_update_queue

Overview:
- Buffers BTB update requests (redirect-driven installs and clears) from the FE redirect/commit logic. Presents them one at a time to the BTB synchronous write port.
- Holds each request until the BTB accepts it. The BTB can refuse a write when it collides with a concurrent read.
- Merges requests to an index already pending, so at most one pending entry exists per BTB index.
- Raises the force flag on the write port when an entry stalls too long or the queue is full.

Parameters:
- vaddr_width_p, 39, virtual address / branch target width.
- btb_tag_width_p, 9, BTB tag width.
- btb_idx_width_p, 6, BTB index width.
- els_p, 4, queue depth in entries; must be ≥2.
- stall_limit_p, 8, consecutive unaccepted cycles before the head is forced; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  reset; one clock; reset is asynchronous and active-low.
- init_done_i  in  1  BTB initialization complete; no writes are presented while low.
- flush_i  in  1  discard all pending updates.
- v_i  in  1  update request valid.
- ready_and_o  out  1  queue can accept; v_i & ready_and_o is a handshake.
- clr_i  in  1  request invalidates the entry.
- jmp_i  in  1  target is an unconditional jump.
- tag_i  in  btb_tag_width_p  update tag.
- idx_i  in  btb_idx_width_p  update index.
- tgt_i  in  vaddr_width_p  branch target.
- w_v_o  out  1  head entry valid toward the BTB.
- w_clr_o, w_jmp_o  out  1 each  head fields.
- w_tag_o  out  btb_tag_width_p  head field.
- w_idx_o  out  btb_idx_width_p  head field.
- w_tgt_o  out  vaddr_width_p  head field.
- w_force_o  out  1  head must win over a same-index read.
- w_yumi_i  in  1  BTB consumed the head this cycle; legal only when w_v_o=1.
- count_o  out  $clog2(els_p+1)  number of pending entries.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - All valid bits, pointers, count and age counter clear.
  - Outputs w_v_o=0, w_force_o=0, count_o=0, ready_and_o=1. Payload outputs are don't-care.
- Storage:
  - Circular FIFO of els_p entries {clr, jmp, tag, idx, tgt} with read/write pointers that wrap at els_p.
  - count_o is registered.
- ready_and_o = (count_o != els_p) & ~flush_i.
  - Depends only on state and flush_i, never on v_i or idx_i.
  - No enqueue-while-full bypass, even when w_yumi_i is high the same cycle.
- Presentation:
  - w_v_o = (count_o != 0) & init_done_i.
  - Payload outputs come straight from the head entry registers (zero latency).
  - An entry accepted at edge N is visible at the head no earlier than cycle N+1.
  - Zero-latency presentation requires an empty queue.
- Pop: w_yumi_i advances the read pointer at the clock edge; the next entry appears the following cycle.
- Merge on enqueue handshake:
  - If idx_i equals the idx of a pending entry, that entry's clr/jmp/tag/tgt are overwritten in place. Count and order are unchanged.
  - Exception: the matching entry is the head and w_yumi_i=1 that cycle. The request is then appended as a new entry.
  - At most one entry ever matches (unique-index invariant).
  - With no match, the request is appended at the tail.
- Simultaneous enqueue and pop: pop applies first, then append or merge; count is unchanged on append+pop.
- Age counter:
  - Width $clog2(stall_limit_p+1).
  - Clears on w_yumi_i, on flush, and whenever w_v_o=0.
  - Otherwise increments each cycle with w_v_o=1 & w_yumi_i=0, saturating at stall_limit_p.
  - A merge into the head does not clear age.
- w_force_o = w_v_o & ((age == stall_limit_p) | (count_o == els_p)).
- flush_i=1:
  - At the next edge, count, pointers and age become 0.
  - A same-cycle enqueue is refused (ready_and_o=0).
  - A same-cycle w_yumi_i is ignored beyond the flush.
  - w_v_o remains combinationally driven from pre-flush state during the flush cycle.
- init_done_i=0: entries accumulate up to els_p; age stays 0 (w_v_o=0).
- Reset asserted mid-operation: pending entries are lost immediately; no partial write is presented after release.

Test Plan:
- Reset, then 3 enqueues idx 5,6,7 with init_done_i=1 and w_yumi_i tied to w_v_o:
  - w_v_o is first high the cycle after the first handshake.
  - w_idx_o sequence is 5,6,7; count_o returns to 0.
- w_yumi_i=0; enqueue idx=3 tgt=0x100 then idx=3 tgt=0x200:
  - count_o=1; head w_tgt_o=0x200.
  - Repeat with w_yumi_i=1 on the second enqueue cycle: count_o=1 afterward, w_tgt_o=0x200.
- Fill 4 distinct indices with w_yumi_i=0:
  - ready_and_o=0 and w_force_o=1 when count_o=4.
  - A single w_yumi_i gives count_o=3, ready_and_o=1.
- One entry, w_yumi_i=0 with stall_limit_p=8:
  - w_force_o rises on the 9th cycle w_v_o is high.
  - A yumi then clears force and age.
- 3 pending entries, flush_i with a concurrent v_i:
  - Next cycle count_o=0, w_v_o=0.
  - The concurrent request is not stored (ready_and_o was 0).
- init_done_i=0, enqueue 2 entries:
  - w_v_o=0 and w_force_o=0 throughout.
  - Raising init_done_i presents the first entry the same cycle.
- Assert reset_i=0 asynchronously between edges with 2 pending:
  - w_v_o and count_o drop to 0 before the next edge.
